// File: rtl/mux_pkg.sv
// mux_pkg: shared types and constants for the N:1 pipelined datapath multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {EMPTY, FULL, FULL_SKID} stage_t;

    localparam int DEFAULT_DATA_WIDTH = 11;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: output register plus one-entry skid so in_ready never depends on out_ready.
module skid_buffer
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    stage_t state, nxt;
    logic [DATA_WIDTH-1:0] skid_data;
    logic accept, drain, load_out, load_skid;

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_valid = state != EMPTY;
    assign load_out  = (state == EMPTY && accept) || (state == FULL && accept && drain) ||
                       (state == FULL_SKID && drain);
    assign load_skid = state == FULL && accept && !drain;

    always_comb begin
        nxt = state;
        if (state == EMPTY && accept)
            nxt = FULL;
        else if (state == FULL && load_skid)
            nxt = FULL_SKID;
        else if (state == FULL && drain && !accept)
            nxt = EMPTY;
        else if (state == FULL_SKID && drain)
            nxt = FULL;
    end

    // in_ready is a flop of the next state, so it comes up one edge after reset release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            state    <= nxt;
            in_ready <= nxt != FULL_SKID;
            if (load_out)
                out_data <= (state == FULL_SKID) ? skid_data : in_data;
            if (load_skid)
                skid_data <= in_data;
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N:1 select with range trap, sticky error flag and delivered-word counter.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_INPUTS = 3,
    parameter int SEL_WIDTH  = sel_width(NUM_INPUTS)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]             select_nx1,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            mux_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             sel_error,
    input  logic                             err_clear,
    output logic [7:0]                       xfer_count
);

    logic [DATA_WIDTH-1:0] sel_data;
    logic in_range, bad_xfer;

    assign in_range = 32'(select_nx1) < NUM_INPUTS;
    assign bad_xfer = in_valid && in_ready && !in_range;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++)
            if (32'(select_nx1) == k)
                sel_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // out-of-range words are still handshaken on the input side but never reach the stage
    skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_data   (sel_data),
        .in_valid  (in_valid && in_range),
        .in_ready  (in_ready),
        .out_data  (mux_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_error  <= 1'b0;
            xfer_count <= '0;
        end else begin
            sel_error  <= bad_xfer ? 1'b1 : (err_clear ? 1'b0 : sel_error);
            xfer_count <= xfer_count + 8'(out_valid && out_ready);
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb_mux_nx1_pipe: directed table-driven checks plus skid, reset, wrap and parameter-sweep sequences.
module tb_mux_nx1_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [32:0] in_data;
    logic [1:0]  select_nx1 = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0, err_clear = 1'b0;
    logic        in_ready, out_valid, sel_error;
    logic [10:0] mux_out;
    logic [7:0]  xfer_count;

    logic [79:0] in_data2;
    logic [2:0]  select2 = '0;
    logic        in_valid2 = 1'b0, out_ready2 = 1'b0, err_clear2 = 1'b0;
    logic        in_ready2, out_valid2, sel_error2;
    logic [15:0] mux_out2;
    logic [7:0]  xfer_count2;

    int tests = 0, fails = 0;
    logic [10:0] lanes [3];

    typedef struct {
        logic [1:0]  sel;
        logic        v, ordy, clr;
        logic [10:0] out;
        logic        ov, ir, err;
        logic [7:0]  cnt;
    } vec_t;
    vec_t tv [16];

    mux_nx1_pipe dut (
        .clock(clock), .reset(reset), .in_data(in_data), .select_nx1(select_nx1),
        .in_valid(in_valid), .in_ready(in_ready), .mux_out(mux_out), .out_valid(out_valid),
        .out_ready(out_ready), .sel_error(sel_error), .err_clear(err_clear), .xfer_count(xfer_count)
    );

    mux_nx1_pipe #(.DATA_WIDTH(16), .NUM_INPUTS(5)) dut2 (
        .clock(clock), .reset(reset), .in_data(in_data2), .select_nx1(select2),
        .in_valid(in_valid2), .in_ready(in_ready2), .mux_out(mux_out2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sel_error(sel_error2), .err_clear(err_clear2), .xfer_count(xfer_count2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic v, input logic o, input logic c);
        select_nx1 = s;
        in_valid   = v;
        out_ready  = o;
        err_clear  = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        lanes[0] = 11'b00000000000;
        lanes[1] = 11'b00001110001;
        lanes[2] = 11'b11110000010;
        in_data  = {lanes[2], lanes[1], lanes[0]};
        in_data2 = {16'hA5C3, 16'h1234, 16'h0F0F, 16'h8001, 16'h7FFE};

        //        sel  v  ordy clr  out      ov ir err cnt
        tv[0]  = '{2'd1, 1, 1, 0, lanes[1], 1, 1, 0, 8'd0};
        tv[1]  = '{2'd2, 1, 1, 0, lanes[2], 1, 1, 0, 8'd1};
        tv[2]  = '{2'd0, 0, 1, 0, lanes[2], 0, 1, 0, 8'd2};
        tv[3]  = '{2'd2, 1, 0, 0, lanes[2], 1, 1, 0, 8'd2};
        tv[4]  = '{2'd0, 1, 0, 0, lanes[2], 1, 0, 0, 8'd2};
        tv[5]  = '{2'd1, 1, 0, 0, lanes[2], 1, 0, 0, 8'd2};
        tv[6]  = '{2'd0, 0, 1, 0, lanes[0], 1, 1, 0, 8'd3};
        tv[7]  = '{2'd0, 0, 1, 0, lanes[0], 0, 1, 0, 8'd4};
        tv[8]  = '{2'd3, 1, 1, 0, lanes[0], 0, 1, 1, 8'd4};
        tv[9]  = '{2'd0, 0, 0, 1, lanes[0], 0, 1, 0, 8'd4};
        tv[10] = '{2'd3, 1, 0, 1, lanes[0], 0, 1, 1, 8'd4};
        tv[11] = '{2'd0, 0, 0, 1, lanes[0], 0, 1, 0, 8'd4};
        tv[12] = '{2'd3, 0, 0, 0, lanes[0], 0, 1, 0, 8'd4};
        tv[13] = '{2'd1, 1, 0, 0, lanes[1], 1, 1, 0, 8'd4};
        tv[14] = '{2'd3, 1, 0, 0, lanes[1], 1, 1, 1, 8'd4};
        tv[15] = '{2'd0, 0, 1, 1, lanes[1], 0, 1, 0, 8'd5};

        do_reset();
        chk("reset mux_out", 32'(mux_out), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset sel_error", 32'(sel_error), 32'd0);
        chk("reset xfer_count", 32'(xfer_count), 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].sel, tv[i].v, tv[i].ordy, tv[i].clr);
            step();
            chk($sformatf("vec%0d mux_out", i), 32'(mux_out), 32'(tv[i].out));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tv[i].ov));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tv[i].ir));
            chk($sformatf("vec%0d sel_error", i), 32'(sel_error), 32'(tv[i].err));
            chk($sformatf("vec%0d xfer_count", i), 32'(xfer_count), 32'(tv[i].cnt));
        end

        // fill the skid with an error pending, then reset between edges
        drive(2'd3, 1, 0, 0); step();
        drive(2'd1, 1, 0, 0); step();
        drive(2'd2, 1, 0, 0); step();
        chk("skid in_ready", 32'(in_ready), 32'd0);
        chk("skid sel_error", 32'(sel_error), 32'd1);
        drive(2'd0, 0, 0, 0);
        #3 reset = 1'b1;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async xfer_count", 32'(xfer_count), 32'd0);
        chk("async sel_error", 32'(sel_error), 32'd0);
        chk("async mux_out", 32'(mux_out), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 256; i++) begin
            drive(2'(i % 3), 1, 1, 0);
            step();
            chk($sformatf("wrap%0d mux_out", i), 32'(mux_out), 32'(lanes[i % 3]));
        end
        chk("wrap count 255", 32'(xfer_count), 32'd255);
        drive(2'd0, 0, 1, 0);
        step();
        chk("wrap count 0", 32'(xfer_count), 32'd0);
        chk("wrap out_valid", 32'(out_valid), 32'd0);

        select2 = 3'd4; in_valid2 = 1'b1; out_ready2 = 1'b1;
        step();
        chk("p5 mux_out", 32'(mux_out2), 32'h0000A5C3);
        chk("p5 out_valid", 32'(out_valid2), 32'd1);
        select2 = 3'd5;
        step();
        chk("p5 drain count", 32'(xfer_count2), 32'd1);
        chk("p5 bad sel", 32'(sel_error2), 32'd1);
        chk("p5 bad no fwd", 32'(out_valid2), 32'd0);
        select2 = 3'd0;
        step();
        chk("p5 lane0", 32'(mux_out2), 32'h00007FFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
